// File: rtl/vga_grid_renderer_if.sv
// Signal bundle between the VGA driver/game logic side and the grid renderer.
// The renderer uses the slave modport; the driver and game logic use the master modport.
interface vga_grid_renderer_if;
    logic [31:0] next_x;
    logic [31:0] next_y;
    logic        v_sync;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [1:0]  wr_col;
    logic [1:0]  wr_val;
    logic        clear;
    logic [23:0] pixel_color;
    logic [1:0]  cursor_row;
    logic [1:0]  cursor_col;
    logic        frame_tick;

    modport master (
        output next_x, next_y, v_sync,
        output btn_up, btn_down, btn_left, btn_right,
        output wr_en, wr_row, wr_col, wr_val, clear,
        input  pixel_color, cursor_row, cursor_col, frame_tick
    );

    modport slave (
        input  next_x, next_y, v_sync,
        input  btn_up, btn_down, btn_left, btn_right,
        input  wr_en, wr_row, wr_col, wr_val, clear,
        output pixel_color, cursor_row, cursor_col, frame_tick
    );
endinterface

// File: rtl/vga_grid_renderer.sv
// Pixel source for a GRID_N x GRID_N board: double-buffered cell array committed at
// frame start, button-driven cursor, zero-latency colour lookup from driver coordinates.
module vga_grid_renderer #(
    parameter int GRID_N    = 3,
    parameter int CELL_LOG2 = 7,
    parameter int X_OFFSET  = 128,
    parameter int Y_OFFSET  = 48,
    parameter int BORDER    = 4
) (
    input  logic clk_in,
    input  logic reset,
    vga_grid_renderer_if.slave bus
);

    localparam int          CELLS     = GRID_N * GRID_N;
    localparam logic [31:0] X_OFF     = 32'(X_OFFSET);
    localparam logic [31:0] Y_OFF     = 32'(Y_OFFSET);
    localparam logic [31:0] BOARD_PX  = 32'(GRID_N) << CELL_LOG2;
    localparam logic [31:0] CELL_MASK = (32'd1 << CELL_LOG2) - 32'd1;
    localparam logic [31:0] EDGE_LO   = 32'(BORDER);
    localparam logic [31:0] EDGE_HI   = (32'd1 << CELL_LOG2) - 32'(BORDER);
    localparam logic [1:0]  LAST      = 2'(GRID_N - 1);

    logic [CELLS-1:0][1:0] shadow_q;
    logic [CELLS-1:0][1:0] shadow_nxt;
    logic [CELLS-1:0][1:0] display_q;
    logic                  v_sync_q;
    logic                  frame_tick_q;
    logic                  frame_start;
    logic [3:0]            btn_q;
    logic                  up_rise, down_rise, left_rise, right_rise;
    logic [1:0]            cursor_row_q, cursor_col_q;
    logic [1:0]            row_nxt, col_nxt;

    // ---------------- shadow array next state ----------------
    always_comb begin
        shadow_nxt = shadow_q;
        if (bus.clear) begin
            shadow_nxt = '0;
        end else if (bus.wr_en) begin
            // out-of-range rows/cols match no cell, so those writes fall away
            for (int r = 0; r < GRID_N; r++) begin
                for (int c = 0; c < GRID_N; c++) begin
                    if (bus.wr_row == 2'(r) && bus.wr_col == 2'(c))
                        shadow_nxt[r*GRID_N + c] = bus.wr_val;
                end
            end
        end
    end

    assign frame_start = v_sync_q & ~bus.v_sync;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            shadow_q     <= '0;
            display_q    <= '0;
            v_sync_q     <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_nxt;
            v_sync_q     <= bus.v_sync;
            frame_tick_q <= frame_start;
            if (frame_start)
                display_q <= shadow_nxt;
        end
    end

    // ---------------- cursor ----------------
    assign up_rise    = bus.btn_up    & ~btn_q[0];
    assign down_rise  = bus.btn_down  & ~btn_q[1];
    assign left_rise  = bus.btn_left  & ~btn_q[2];
    assign right_rise = bus.btn_right & ~btn_q[3];

    always_comb begin
        row_nxt = cursor_row_q;
        col_nxt = cursor_col_q;
        if (up_rise && !down_rise)
            row_nxt = (cursor_row_q == 2'd0) ? LAST : cursor_row_q - 2'd1;
        else if (down_rise && !up_rise)
            row_nxt = (cursor_row_q == LAST) ? 2'd0 : cursor_row_q + 2'd1;
        if (left_rise && !right_rise)
            col_nxt = (cursor_col_q == 2'd0) ? LAST : cursor_col_q - 2'd1;
        else if (right_rise && !left_rise)
            col_nxt = (cursor_col_q == LAST) ? 2'd0 : cursor_col_q + 2'd1;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_q        <= '0;
            cursor_row_q <= '0;
            cursor_col_q <= '0;
        end else begin
            btn_q        <= {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
            cursor_row_q <= row_nxt;
            cursor_col_q <= col_nxt;
        end
    end

    // ---------------- colour path ----------------
    logic [31:0] bx, by, ox, oy, col_w, row_w;
    logic        on_board, is_edge, is_cursor;
    logic [1:0]  cell_val;
    logic [23:0] color;

    assign bx    = bus.next_x - X_OFF;
    assign by    = bus.next_y - Y_OFF;
    assign col_w = bx >> CELL_LOG2;
    assign row_w = by >> CELL_LOG2;
    assign ox    = bx & CELL_MASK;
    assign oy    = by & CELL_MASK;

    assign on_board  = (bus.next_x >= X_OFF) && (bus.next_y >= Y_OFF) &&
                       (bx < BOARD_PX) && (by < BOARD_PX);
    assign is_edge   = (ox < EDGE_LO) || (ox >= EDGE_HI) || (oy < EDGE_LO) || (oy >= EDGE_HI);
    assign is_cursor = (row_w == {30'd0, cursor_row_q}) && (col_w == {30'd0, cursor_col_q});

    always_comb begin
        cell_val = 2'd0;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                if (row_w == 32'(r) && col_w == 32'(c))
                    cell_val = display_q[r*GRID_N + c];
            end
        end
    end

    always_comb begin
        color = 24'h000000;
        if (on_board) begin
            if (is_edge) begin
                color = is_cursor ? 24'hFFFF00 : 24'hFFFFFF;
            end else begin
                case (cell_val)
                    2'd0:    color = 24'h202020;
                    2'd1:    color = 24'hFF0000;
                    2'd2:    color = 24'h0000FF;
                    default: color = 24'h00FF00;
                endcase
            end
        end
    end

    assign bus.pixel_color = color;
    assign bus.cursor_row  = cursor_row_q;
    assign bus.cursor_col  = cursor_col_q;
    assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Bench for vga_grid_renderer: board-level reference model checked every cycle,
// plus directed probes with hand-computed colours.
module tb_vga_grid_renderer;
    localparam int N = 3;

    logic clk_in = 1'b0;
    logic reset;
    always #20 clk_in = ~clk_in;

    vga_grid_renderer_if bus ();

    vga_grid_renderer #(
        .GRID_N(3), .CELL_LOG2(7), .X_OFFSET(128), .Y_OFFSET(48), .BORDER(4)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 0;

    // reference model state
    int m_shadow [N][N];
    int m_disp   [N][N];
    int m_row, m_col;
    bit m_tick, m_vs_prev;
    bit m_up_p, m_dn_p, m_lf_p, m_rt_p;

    function automatic logic [23:0] model_color(longint x, longint y);
        longint bx, by, ox, oy;
        int r, c;
        bx = x - 128;
        by = y - 48;
        if (x < 128 || y < 48 || bx >= N * 128 || by >= N * 128) return 24'h000000;
        c  = int'(bx / 128);
        r  = int'(by / 128);
        ox = bx % 128;
        oy = by % 128;
        if (ox < 4 || ox >= 124 || oy < 4 || oy >= 124)
            return (r == m_row && c == m_col) ? 24'hFFFF00 : 24'hFFFFFF;
        case (m_disp[r][c])
            0:       return 24'h202020;
            1:       return 24'hFF0000;
            2:       return 24'h0000FF;
            default: return 24'h00FF00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // model update at each rising edge from the inputs presented in that cycle
    initial begin
        forever begin
            @(posedge clk_in);
            if (reset) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        m_shadow[r][c] = 0;
                        m_disp[r][c]   = 0;
                    end
                m_row = 0; m_col = 0; m_tick = 0; m_vs_prev = 1;
                m_up_p = 0; m_dn_p = 0; m_lf_p = 0; m_rt_p = 0;
            end else begin
                bit up, dn, lf, rt, fs;
                if (bus.clear) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) m_shadow[r][c] = 0;
                end else if (bus.wr_en && int'(bus.wr_row) < N && int'(bus.wr_col) < N) begin
                    m_shadow[bus.wr_row][bus.wr_col] = int'(bus.wr_val);
                end
                fs = m_vs_prev && !bus.v_sync;
                if (fs) m_disp = m_shadow;
                m_tick    = fs;
                m_vs_prev = bus.v_sync;
                up = bus.btn_up && !m_up_p;
                dn = bus.btn_down && !m_dn_p;
                lf = bus.btn_left && !m_lf_p;
                rt = bus.btn_right && !m_rt_p;
                if (up && !dn) m_row = (m_row + N - 1) % N;
                if (dn && !up) m_row = (m_row + 1) % N;
                if (lf && !rt) m_col = (m_col + N - 1) % N;
                if (rt && !lf) m_col = (m_col + 1) % N;
                m_up_p = bus.btn_up; m_dn_p = bus.btn_down;
                m_lf_p = bus.btn_left; m_rt_p = bus.btn_right;
            end
        end
    end

    // compare process: every falling edge once the bench is out of its first reset
    initial begin
        forever begin
            @(negedge clk_in);
            if (checking) begin
                check("model_pixel", {8'd0, bus.pixel_color},
                      {8'd0, model_color(longint'(bus.next_x), longint'(bus.next_y))});
                check("model_cursor_row", {30'd0, bus.cursor_row}, 32'(m_row));
                check("model_cursor_col", {30'd0, bus.cursor_col}, 32'(m_col));
                check("model_frame_tick", {31'd0, bus.frame_tick}, {31'd0, m_tick});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [23:0] exp);
        bus.next_x = 32'(x);
        bus.next_y = 32'(y);
        @(negedge clk_in);
        check(name, {8'd0, bus.pixel_color}, {8'd0, exp});
        step(1);
    endtask

    task automatic vsync_pulse();
        bus.v_sync = 1'b0;
        step(1);
        bus.v_sync = 1'b1;
        step(1);
    endtask

    task automatic write_cell(input int r, input int c, input int v);
        bus.wr_en = 1'b1; bus.wr_row = 2'(r); bus.wr_col = 2'(c); bus.wr_val = 2'(v);
        step(1);
        bus.wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.next_x = 0; bus.next_y = 0; bus.v_sync = 1'b1;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.wr_en = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_val = 0; bus.clear = 0;
        step(3);
        reset = 1'b0;
        checking = 1;
        @(negedge clk_in);
        check("reset_row", {30'd0, bus.cursor_row}, 32'd0);
        check("reset_col", {30'd0, bus.cursor_col}, 32'd0);
        check("reset_tick", {31'd0, bus.frame_tick}, 32'd0);
        step(1);

        vsync_pulse();
        probe("cursor_edge",   130, 50,  24'hFFFF00);
        probe("empty_cell",    200, 100, 24'h202020);
        probe("blank_region",  10,  10,  24'h000000);
        probe("right_of_board",600, 100, 24'h000000);
        probe("last_col_px",   511, 100, 24'hFFFFFF);
        probe("past_board_x",  512, 100, 24'h000000);
        probe("before_board_x",127, 100, 24'h000000);

        // buffered write becomes visible only after commit
        bus.next_x = 444; bus.next_y = 236;
        write_cell(1, 2, 1);
        @(negedge clk_in);
        check("pre_commit", {8'd0, bus.pixel_color}, 32'h202020);
        step(1);
        bus.v_sync = 1'b0;
        @(negedge clk_in);
        check("commit_cycle_px", {8'd0, bus.pixel_color}, 32'h202020);
        check("commit_cycle_tick", {31'd0, bus.frame_tick}, 32'd0);
        step(1);
        bus.v_sync = 1'b1;
        @(negedge clk_in);
        check("post_commit_px", {8'd0, bus.pixel_color}, 32'hFF0000);
        check("tick_high", {31'd0, bus.frame_tick}, 32'd1);
        step(1);
        @(negedge clk_in);
        check("tick_one_cycle", {31'd0, bus.frame_tick}, 32'd0);
        step(1);

        // held button moves once
        bus.btn_right = 1; step(10); bus.btn_right = 0; step(1);
        check("hold_right_col", {30'd0, bus.cursor_col}, 32'd1);
        bus.btn_up = 1; step(1); bus.btn_up = 0; step(1);
        check("up_wrap_row2", {30'd0, bus.cursor_row}, 32'd2);
        bus.btn_up = 1; step(1); bus.btn_up = 0; step(1);
        check("up_row1", {30'd0, bus.cursor_row}, 32'd1);
        bus.btn_up = 1; step(1); bus.btn_up = 0; step(1);
        check("up_row0", {30'd0, bus.cursor_row}, 32'd0);

        bus.btn_left = 1; bus.btn_right = 1; step(1);
        bus.btn_left = 0; bus.btn_right = 0; step(1);
        check("lr_cancel_col", {30'd0, bus.cursor_col}, 32'd1);
        bus.btn_down = 1; step(1); bus.btn_down = 0; step(1);
        check("down_row1", {30'd0, bus.cursor_row}, 32'd1);
        probe("cursor_cell_edge", 128 + 128 + 1, 48 + 128 + 60, 24'hFFFF00);

        // clear beats write, both folded into the commit on the same edge
        bus.clear = 1; bus.wr_en = 1; bus.wr_row = 0; bus.wr_col = 0; bus.wr_val = 2;
        bus.v_sync = 1'b0;
        step(1);
        bus.clear = 0; bus.wr_en = 0; bus.v_sync = 1'b1;
        probe("clear_wins_00", 200, 100, 24'h202020);
        probe("clear_wins_12", 444, 236, 24'h202020);

        // fill board, commit, then reset mid-frame
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write_cell(r, c, ((r * N + c) % 3) + 1);
        write_cell(3, 1, 2);
        vsync_pulse();
        probe("filled_00", 200, 100, 24'hFF0000);
        probe("filled_01", 328, 100, 24'h0000FF);
        probe("filled_02", 456, 100, 24'h00FF00);
        reset = 1'b1;
        step(1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                probe("reset_interior", 128 + c * 128 + 60, 48 + r * 128 + 60, 24'h202020);
        check("reset_mid_row", {30'd0, bus.cursor_row}, 32'd0);
        check("reset_mid_col", {30'd0, bus.cursor_col}, 32'd0);
        check("reset_mid_tick", {31'd0, bus.frame_tick}, 32'd0);
        reset = 1'b0;
        step(2);

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_grid_renderer.md
Name: vga_grid_renderer

Overview:
- Pixel-source stage directly upstream of the VGA driver.
- Takes the driver's next_x/next_y pixel coordinates and returns pixel_color (24-bit RGB) for a square GRID_N x GRID_N board.
- Holds a cell-state array written by game logic, and a button-driven cursor.
- Cell updates are double-buffered: the displayed array is refreshed only at frame start, so a frame never tears mid-scan.

Parameters:
- GRID_N, 3, cells per row/column (2..4).
- CELL_LOG2, 7, log2 of cell side in pixels (cell = 128 px).
- X_OFFSET, 128, left edge of board in pixels.
- Y_OFFSET, 48, top edge of board in lines.
- BORDER, 4, grid-line thickness in pixels, drawn inside each cell edge.

Ports:
- clk_in  in  1  pixel clock (25 MHz), shared with driver.
- reset  in  1  synchronous, active-high.
- next_x  in  32  pixel column from driver (0 outside active region).
- next_y  in  32  pixel line from driver (0 outside active region).
- v_sync  in  1  driver vertical sync, active-low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  level inputs, already synchronised/debounced.
- wr_en  in  1  write strobe into shadow array.
- wr_row, wr_col  in  2 each  target cell.
- wr_val  in  2  cell value: 0 empty, 1 player A, 2 player B, 3 highlight.
- clear  in  1  zero entire shadow array.
- pixel_color  out  24  RRGGBB to driver.
- cursor_row, cursor_col  out  2 each  current cursor cell.
- frame_tick  out  1  one-cycle pulse at each commit.

Behaviour:
- Reset (synchronous, active-high, clock clk_in) clears:
  - shadow and display arrays = 0; cursor = (0,0); frame_tick = 0.
  - button edge registers = 0; v_sync_q = 1.
  - Reset mid-frame is legal. pixel_color then reflects empty board + cursor at (0,0) from the next cycle.
- Colour path: pixel_color is combinational from next_x/next_y and registered state, with zero latency. The driver samples it on the same edge it presents the coordinates.
- Board coordinates: bx = next_x - X_OFFSET, by = next_y - Y_OFFSET, computed 32-bit.
  - Pixel is on-board iff next_x >= X_OFFSET, next_y >= Y_OFFSET, and bx, by < GRID_N << CELL_LOG2.
  - Off-board -> 24'h000000. Coordinates (0,0) during blanking therefore yield black.
- Cell index: col = bx >> CELL_LOG2, row = by >> CELL_LOG2. Offset within cell: ox = bx[CELL_LOG2-1:0], oy likewise.
- Edge pixel: ox < BORDER, or ox >= CELL - BORDER, or the same test on oy.
- Edge pixel colour: 24'hFFFF00 if (row,col) == cursor, else 24'hFFFFFF.
- Interior colour by display value: 0 -> 24'h202020, 1 -> 24'hFF0000, 2 -> 24'h0000FF, 3 -> 24'h00FF00.
- Writes:
  - wr_en updates shadow[wr_row][wr_col] at the clock edge.
  - Writes with wr_row or wr_col >= GRID_N are ignored.
  - clear has priority over wr_en in the same cycle: array is zeroed, write dropped.
- Commit:
  - v_sync_q <= v_sync each cycle; a falling edge (v_sync_q=1, v_sync=0) is frame start.
  - On that cycle, display <= next-state of shadow, so a write/clear in the same cycle is included.
  - frame_tick = 1 in the following cycle only.
- Cursor:
  - Each button is edge-detected; one move per rising edge. Holding a button gives no repeat.
  - up: row = (row==0) ? GRID_N-1 : row-1; down: row = (row==GRID_N-1) ? 0 : row+1. Left/right act the same on col.
  - up and down rising in the same cycle -> no row change; left and right together -> no col change.
  - A row move and a col move in the same cycle both apply.
  - Cursor changes are visible immediately (not frame-buffered).
- cursor_row/cursor_col are registered outputs.

Test Plan:
- Reset, then v_sync pulse; probe (next_x,next_y) = (130,50) -> FFFF00; (200,100) -> 202020; (10,10) -> 000000; (600,100) -> 000000.
- wr_en row1 col2 val1 mid-frame; probe (128+256+60, 48+128+60) -> 202020 until v_sync falls, then FF0000 with frame_tick = 1 for exactly one cycle.
- Hold btn_right 10 cycles -> cursor_col = 1 only. Three rising edges of btn_up from row 0 -> rows 2, 1, 0 (wrap).
- btn_left and btn_right rise on the same cycle -> cursor_col unchanged. btn_down alone -> cursor_row +1.
- clear and wr_en (row0 col0 val2) asserted on the same cycle as the v_sync falling edge -> committed cell (0,0) = 0, probe colour 202020.
- Fill cells with values 1..3, assert reset mid-frame -> next cycle all interiors 202020, cursor (0,0), frame_tick 0.
